// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, condition-code encodings, default width.
// Used by the result queue and by the branch unit's condition evaluator.
package alu_pkg;

   localparam int ALU_DATA_W = 16;
   localparam int FLAG_W     = 5;

   // Bit positions inside the packed flag vector {V,CY,P,ZR,S}
   localparam int FLG_S  = 0;
   localparam int FLG_ZR = 1;
   localparam int FLG_P  = 2;
   localparam int FLG_CY = 3;
   localparam int FLG_V  = 4;

   typedef logic [FLAG_W-1:0] flags_t;

   localparam logic [3:0] COND_ALWAYS = 4'd0;
   localparam logic [3:0] COND_EQ     = 4'd1;
   localparam logic [3:0] COND_NE     = 4'd2;
   localparam logic [3:0] COND_CS     = 4'd3;
   localparam logic [3:0] COND_CC     = 4'd4;
   localparam logic [3:0] COND_MI     = 4'd5;
   localparam logic [3:0] COND_PL     = 4'd6;
   localparam logic [3:0] COND_VS     = 4'd7;
   localparam logic [3:0] COND_VC     = 4'd8;
   localparam logic [3:0] COND_PS     = 4'd9;
   localparam logic [3:0] COND_PC     = 4'd10;
   localparam logic [3:0] COND_GE     = 4'd11;
   localparam logic [3:0] COND_LT     = 4'd12;
   localparam logic [3:0] COND_GT     = 4'd13;
   localparam logic [3:0] COND_LE     = 4'd14;
   localparam logic [3:0] COND_NEVER  = 4'd15;

   // Packs individual ALU flag bits into the shared flag layout.
   function automatic flags_t pack_flags(input logic s, input logic zr, input logic p,
                                         input logic cy, input logic v);
      flags_t f;
      f         = '0;
      f[FLG_S]  = s;
      f[FLG_ZR] = zr;
      f[FLG_P]  = p;
      f[FLG_CY] = cy;
      f[FLG_V]  = v;
      return f;
   endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational condition-code evaluator: maps (flags, cond_sel) to cond_true.
// Shared between the result queue head and the branch unit.
module alu_cond_eval
   import alu_pkg::*;
(
   input  logic [FLAG_W-1:0] flags,
   input  logic [3:0]        cond_sel,
   output logic              cond_true
);

   logic s;
   logic zr;
   logic p;
   logic cy;
   logic v;

   assign s  = flags[FLG_S];
   assign zr = flags[FLG_ZR];
   assign p  = flags[FLG_P];
   assign cy = flags[FLG_CY];
   assign v  = flags[FLG_V];

   always_comb begin
      cond_true = 1'b0;
      case (cond_sel)
         COND_ALWAYS: cond_true = 1'b1;
         COND_EQ:     cond_true = zr;
         COND_NE:     cond_true = !zr;
         COND_CS:     cond_true = cy;
         COND_CC:     cond_true = !cy;
         COND_MI:     cond_true = s;
         COND_PL:     cond_true = !s;
         COND_VS:     cond_true = v;
         COND_VC:     cond_true = !v;
         COND_PS:     cond_true = p;
         COND_PC:     cond_true = !p;
         // Signed comparisons derive from S xor V, as after a subtract.
         COND_GE:     cond_true = (s == v);
         COND_LT:     cond_true = (s != v);
         COND_GT:     cond_true = !zr && (s == v);
         COND_LE:     cond_true = zr || (s != v);
         COND_NEVER:  cond_true = 1'b0;
         default:     cond_true = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_result_queue.sv
// ALU result FIFO with head condition evaluation, sticky CY/V status and overflow counter.
// Define ALU_FLAG_CHECK_EN to compile in the Z/S/P flag-consistency checker (flag_err).
module alu_result_queue
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_z,
   input  logic              in_sign,
   input  logic              in_parity,
   input  logic              in_carry,
   input  logic              in_overflow,
   input  logic              in_zero,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_z,
   output logic [FLAG_W-1:0] out_flags,
   input  logic [3:0]        cond_sel,
   output logic              cond_true,
   input  logic              clr_sticky,
   output logic              sticky_cy,
   output logic              sticky_v,
   output logic [CNT_W-1:0]  ov_count,
   output logic              flag_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [DATA_W-1:0] z_mem    [DEPTH];
   logic [FLAG_W-1:0] flag_mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   occ_reg;
   logic [PTR_W:0]   occ_next;

   logic             push;
   logic             pop;
   flags_t           in_flags;
   logic             head_cond;

   logic             sticky_cy_reg;
   logic             sticky_v_reg;
   logic [CNT_W-1:0] ov_count_reg;
   logic [CNT_W-1:0] ov_count_next;

   assign in_flags  = pack_flags(in_sign, in_zero, in_parity, in_carry, in_overflow);

   // in_ready looks only at registered occupancy: no bypass when full.
   assign in_ready  = (occ_reg != OCC_FULL);
   assign out_valid = (occ_reg != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Payload storage; no reset needed because reads are masked by out_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         z_mem[wr_ptr_reg]    <= in_z;
         flag_mem[wr_ptr_reg] <= in_flags;
      end
   end

   always_comb begin
      occ_next = occ_reg;
      case ({push, pop})
         2'b10:   occ_next = occ_reg + (PTR_W+1)'(1);
         2'b01:   occ_next = occ_reg - (PTR_W+1)'(1);
         default: occ_next = occ_reg;
      endcase
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         occ_reg <= occ_next;
      end
   end

   assign out_z     = out_valid ? z_mem[rd_ptr_reg]    : '0;
   assign out_flags = out_valid ? flag_mem[rd_ptr_reg] : '0;

   alu_cond_eval u_cond_eval (
      .flags     (out_flags),
      .cond_sel  (cond_sel),
      .cond_true (head_cond)
   );

   assign cond_true = out_valid && head_cond;

   // A flagged push in the same cycle as clr_sticky survives the clear.
   always_comb begin
      ov_count_next = clr_sticky ? '0 : ov_count_reg;
      if (push && in_overflow && (ov_count_next != CNT_MAX)) begin
         ov_count_next = ov_count_next + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_cy_reg <= 1'b0;
         sticky_v_reg  <= 1'b0;
         ov_count_reg  <= '0;
      end else begin
         sticky_cy_reg <= (sticky_cy_reg && !clr_sticky) || (push && in_carry);
         sticky_v_reg  <= (sticky_v_reg  && !clr_sticky) || (push && in_overflow);
         ov_count_reg  <= ov_count_next;
      end
   end

   assign sticky_cy = sticky_cy_reg;
   assign sticky_v  = sticky_v_reg;
   assign ov_count  = ov_count_reg;

`ifdef ALU_FLAG_CHECK_EN
   logic flag_mismatch;
   logic flag_err_reg;

   assign flag_mismatch = ((in_z == '0) != in_zero)
                       || (in_z[DATA_W-1] != in_sign)
                       || ((^in_z) != in_parity);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_err_reg <= 1'b0;
      end else begin
         flag_err_reg <= (flag_err_reg && !clr_sticky) || (push && flag_mismatch);
      end
   end

   assign flag_err = flag_err_reg;
`else
   assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Scoreboard bench for alu_result_queue: a queue-based reference model records accepted
// pushes, and a negedge monitor compares the DUT head and status against it.
`timescale 1ns/1ps
module tb_alu_result_queue;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [15:0] z;
      logic [4:0]  f;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_z;
   logic        in_sign, in_parity, in_carry, in_overflow, in_zero;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_z;
   logic [4:0]  out_flags;
   logic [3:0]  cond_sel;
   logic        cond_true;
   logic        clr_sticky;
   logic        sticky_cy, sticky_v;
   logic [7:0]  ov_count;
   logic        flag_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   ent_t sb_q[$];
   int   m_occ = 0;
   bit   m_scy = 0, m_sv = 0, m_err = 0;
   int   m_cnt = 0;
   bit   m_push, m_pop;

   alu_result_queue dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_z(in_z),
      .in_sign(in_sign), .in_parity(in_parity), .in_carry(in_carry),
      .in_overflow(in_overflow), .in_zero(in_zero),
      .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_flags(out_flags),
      .cond_sel(cond_sel), .cond_true(cond_true), .clr_sticky(clr_sticky),
      .sticky_cy(sticky_cy), .sticky_v(sticky_v), .ov_count(ov_count), .flag_err(flag_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Condition codes from the flag meanings: f = {V,CY,P,ZR,S}
   function automatic bit cond_model(input logic [4:0] f, input logic [3:0] sel);
      bit s, zr, p, cy, v;
      s = f[0]; zr = f[1]; p = f[2]; cy = f[3]; v = f[4];
      case (sel)
         4'd0:  return 1'b1;
         4'd1:  return zr;
         4'd2:  return !zr;
         4'd3:  return cy;
         4'd4:  return !cy;
         4'd5:  return s;
         4'd6:  return !s;
         4'd7:  return v;
         4'd8:  return !v;
         4'd9:  return p;
         4'd10: return !p;
         4'd11: return s == v;
         4'd12: return s != v;
         4'd13: return !zr && (s == v);
         4'd14: return zr || (s != v);
         default: return 1'b0;
      endcase
   endfunction

   // Model: acceptance and status bookkeeping on each rising edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_q.delete();
         m_occ = 0; m_scy = 0; m_sv = 0; m_err = 0; m_cnt = 0;
      end else begin
         m_push = in_valid && (m_occ < DEPTH);
         m_pop  = out_ready && (m_occ != 0);
         if (clr_sticky) begin
            m_scy = 0; m_sv = 0; m_cnt = 0; m_err = 0;
         end
         if (m_push) begin
            sb_q.push_back('{z: in_z, f: {in_overflow, in_carry, in_parity, in_zero, in_sign}});
            if (in_carry)    m_scy = 1;
            if (in_overflow) m_sv = 1;
            if (in_overflow && m_cnt < 255) m_cnt++;
`ifdef ALU_FLAG_CHECK_EN
            if (((in_z == 16'h0) != in_zero) || (in_z[15] != in_sign) || ((^in_z) != in_parity))
               m_err = 1;
`endif
         end
         m_occ = m_occ + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      end
   end

   // Monitor: compare at the falling edge, retire the head on a handshake
   always @(negedge clk) begin
      ent_t e;
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_occ != DEPTH});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_occ != 0});
      if (m_occ != 0) begin
         if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_empty: got out_valid=%0b with no expected entry", out_valid);
         end else begin
            e = sb_q[0];
            chk("out_z", {16'b0, out_z}, {16'b0, e.z});
            chk("out_flags", {27'b0, out_flags}, {27'b0, e.f});
            chk("cond_true", {31'b0, cond_true}, {31'b0, cond_model(e.f, cond_sel)});
            if (out_ready) begin
               void'(sb_q.pop_front());
               $display("[TB] pop z=%04h flags=%05b", e.z, e.f);
            end
         end
      end else begin
         chk("cond_true_idle", {31'b0, cond_true}, 32'd0);
      end
      chk("sticky_cy", {31'b0, sticky_cy}, {31'b0, m_scy});
      chk("sticky_v", {31'b0, sticky_v}, {31'b0, m_sv});
      chk("ov_count", {24'b0, ov_count}, m_cnt);
      chk("flag_err", {31'b0, flag_err}, {31'b0, m_err});
   end

   task automatic cyc(input bit v, input logic [15:0] z, input logic [4:0] f,
                      input bit ordy, input logic [3:0] cs, input bit clr);
      @(posedge clk); #1;
      in_valid = v; in_z = z;
      {in_overflow, in_carry, in_parity, in_zero, in_sign} = f;
      out_ready = ordy; cond_sel = cs; clr_sticky = clr;
   endtask

   task automatic idle(input bit ordy, input logic [3:0] cs);
      cyc(1'b0, 16'h0, 5'b0, ordy, cs, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 0; in_z = 0; in_sign = 0; in_parity = 0; in_carry = 0;
      in_overflow = 0; in_zero = 0; out_ready = 0; cond_sel = 0; clr_sticky = 0;
      #17;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_z", {16'b0, out_z}, 32'd0);
      chk("rst_ov_count", {24'b0, ov_count}, 32'd0);
      @(negedge clk); #1 rst_n = 1'b1;

      // First result 8fff+8000, then fffe+0002 queued behind it
      cyc(1, 16'h0fff, 5'b11000, 0, 4'd7, 0);
      cyc(1, 16'h0000, 5'b01010, 0, 4'd7, 0);
      @(negedge clk);
      chk("t1_out_z", {16'b0, out_z}, 32'h0fff);
      chk("t1_flags", {27'b0, out_flags}, 32'b11000);
      chk("t1_vs", {31'b0, cond_true}, 32'd1);
      chk("t1_ov", {24'b0, ov_count}, 32'd1);
      idle(0, 4'd1);
      @(negedge clk);
      chk("t1_eq", {31'b0, cond_true}, 32'd0);
      chk("t2_head_hold", {16'b0, out_z}, 32'h0fff);
      idle(1, 4'd1);
      idle(0, 4'd1);
      @(negedge clk);
      chk("t2_out_z", {16'b0, out_z}, 32'h0000);
      chk("t2_eq", {31'b0, cond_true}, 32'd1);
      idle(0, 4'd12);
      @(negedge clk);
      chk("t2_lt", {31'b0, cond_true}, 32'd0);
      chk("t2_ov", {24'b0, ov_count}, 32'd1);
      idle(1, 4'd0);
      idle(0, 4'd0);

      // Fill to DEPTH, offer a fifth entry, then drain
      for (int i = 0; i < 5; i++)
         cyc(1, 16'h0a00 + 16'(i), 5'($urandom), 0, 4'($urandom), 0);
      @(negedge clk);
      chk("full_in_ready", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < 4; i++) idle(1, 4'd0);
      idle(0, 4'd0);
      @(negedge clk);
      chk("drain_out_valid", {31'b0, out_valid}, 32'd0);
      chk("drain_cond", {31'b0, cond_true}, 32'd0);

      // Streaming 0001..0014 with the consumer always ready
      for (int i = 1; i <= 20; i++)
         cyc(1, 16'(i), 5'($urandom), 1, 4'($urandom), 0);
      idle(1, 4'd0);
      idle(1, 4'd0);

      // Clear coinciding with a V=1 push: the push wins
      cyc(1, 16'h0001, 5'b10100, 1, 4'd0, 1);
      idle(1, 4'd0);
      @(negedge clk);
      chk("clr_push_v", {31'b0, sticky_v}, 32'd1);
      chk("clr_push_cnt", {24'b0, ov_count}, 32'd1);

      // Counter saturation
      for (int i = 0; i < 300; i++)
         cyc(1, 16'($urandom), 5'($urandom) | 5'b10000, 1, 4'($urandom), 0);
      idle(1, 4'd0);
      @(negedge clk);
      chk("ov_saturate", {24'b0, ov_count}, 32'hff);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 9) < 7, 16'($urandom), 5'($urandom),
             $urandom_range(0, 9) < 6, 4'($urandom), $urandom_range(0, 49) == 0);
      for (int i = 0; i < 6; i++) idle(1, 4'd0);

`ifdef ALU_FLAG_CHECK_EN
      cyc(0, 16'h0, 5'b0, 1, 4'd0, 1);
      cyc(1, 16'h0000, 5'b00000, 1, 4'd0, 0);
      idle(1, 4'd0);
      @(negedge clk);
      chk("flag_err_set", {31'b0, flag_err}, 32'd1);
      idle(1, 4'd0);
      idle(1, 4'd0);
      @(negedge clk);
      chk("flag_err_hold", {31'b0, flag_err}, 32'd1);
      cyc(0, 16'h0, 5'b0, 1, 4'd0, 1);
      idle(1, 4'd0);
      @(negedge clk);
      chk("flag_err_clr", {31'b0, flag_err}, 32'd0);
`endif

      // Asynchronous reset with three entries queued
      for (int i = 0; i < 3; i++)
         cyc(1, 16'h8000 + 16'(i), 5'b11001, 0, 4'd0, 0);
      idle(0, 4'd0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("arst_out_z", {16'b0, out_z}, 32'd0);
      chk("arst_flags", {27'b0, out_flags}, 32'd0);
      chk("arst_cond", {31'b0, cond_true}, 32'd0);
      chk("arst_sticky", {30'b0, sticky_cy, sticky_v}, 32'd0);
      chk("arst_ov", {24'b0, ov_count}, 32'd0);
      chk("arst_err", {31'b0, flag_err}, 32'd0);
      @(negedge clk); #1 rst_n = 1'b1;
      cyc(1, 16'h1234, 5'b00001, 0, 4'd5, 0);
      idle(0, 4'd5);
      @(negedge clk);
      chk("post_rst_z", {16'b0, out_z}, 32'h1234);
      idle(1, 4'd0);
      idle(0, 4'd0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_result_queue.md
Name: alu_result_queue

Overview:
- Downstream stage of the 16-bit combinational ALU; captures its result Z and flags (Sign, Parity, Carry, Overflow, Zero) into a small FIFO using a valid/ready handshake.
- Presents the oldest result to the writeback/branch logic and evaluates a selectable condition code on the head entry's flags.
- Maintains sticky carry/overflow status and a saturating overflow-event counter for software/debug.

Parameters:
- DATA_W, 16, width of ALU result Z.
- DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  the ALU result on in_z and the flags are valid.
- in_ready  out  1  the queue can accept an entry.
- in_z  in  DATA_W  ALU result Z.
- in_sign, in_parity, in_carry, in_overflow, in_zero  in  1 each  ALU flags.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_z  out  DATA_W  head result.
- out_flags  out  5  head flags, packed {V,CY,P,ZR,S} (bit4..bit0).
- cond_sel  in  4  condition-code select.
- cond_true  out  1  selected condition evaluated on out_flags.
- clr_sticky  in  1  synchronous clear of sticky_cy, sticky_v and ov_count.
- sticky_cy, sticky_v  out  1 each  sticky carry/overflow seen since the last clear.
- ov_count  out  CNT_W  number of pushed entries with V=1; saturates at all-ones.
- flag_err  out  1  sticky flag-consistency error (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - Write/read pointers and occupancy are 0.
  - out_valid=0, in_ready=1.
  - out_z=0, out_flags=0, cond_true=0.
  - sticky_cy=0, sticky_v=0, ov_count=0, flag_err=0.
  - Reset asserted mid-transfer discards all entries; there is no partial state.
- Push occurs when in_valid && in_ready.
  - in_ready = (occupancy != DEPTH); it is a registered-state function and never depends on out_ready.
  - When full, in_ready=0 even if a pop happens in the same cycle (no full-bypass).
- Pop occurs when out_valid && out_ready.
  - out_valid = (occupancy != 0).
  - out_z and out_flags come directly from storage at the read pointer; they are don't-care when out_valid=0 but driven to 0 after reset.
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1. There is no combinational in->out path.
- Simultaneous push and pop when not full and not empty: occupancy is unchanged and both pointers advance.
- Push while empty: out_valid rises next cycle.
- Pointers wrap modulo DEPTH. Occupancy is a separate counter of width log2(DEPTH)+1.
- Sticky status, updated on push:
  - sticky_cy |= in_carry; sticky_v |= in_overflow.
  - ov_count increments when in_overflow=1 and holds at 2^CNT_W-1.
  - clr_sticky in the same cycle as a flagged push: the push wins, leaving the sticky bit =1 and ov_count =1 (if V).
- cond_sel encoding, evaluated combinationally on the head flags; cond_true is forced to 0 when out_valid=0:
  - 0 ALWAYS; 1 EQ (ZR); 2 NE (!ZR); 3 CS (CY); 4 CC (!CY).
  - 5 MI (S); 6 PL (!S); 7 VS (V); 8 VC (!V).
  - 9 PS (P); 10 PC (!P).
  - 11 GE (S==V); 12 LT (S!=V); 13 GT (!ZR && S==V); 14 LE (ZR || S!=V).
  - 15 NEVER.

Optional Feature:
- Macro: ALU_FLAG_CHECK_EN.
- Defined: on each push, recompute zero = (in_z==0), sign = in_z[DATA_W-1] and parity = ^in_z (reduction XOR).
  - Any mismatch with in_zero, in_sign or in_parity sets flag_err on the next edge.
  - flag_err is cleared only by reset or clr_sticky; the error wins over a same-cycle clear.
- Undefined: no checker logic is compiled in and flag_err is tied to 0.

Decomposition:
- Shared package alu_pkg holds:
  - the flag bit-index constants FLG_S=0, FLG_ZR=1, FLG_P=2, FLG_CY=3, FLG_V=4;
  - the 4-bit cond_sel code constants COND_ALWAYS..COND_NEVER;
  - DATA_W default 16.
- One sub-module, alu_cond_eval: combinational mapping of (flags, cond_sel) to cond_true. It is reused by the branch unit.

Test Plan:
- Reset, then push X=8fff+Y=8000 result (Z=0fff, S=0, ZR=0, P=0, CY=1, V=1) -> next cycle out_valid=1, out_z=0fff, out_flags=5'b11000; sticky_cy=1, sticky_v=1, ov_count=1; cond_sel=7 gives cond_true=1, cond_sel=1 gives 0.
- Push Z=0000 with ZR=1, CY=1, V=0, P=0, S=0 (fffe+0002) behind the first entry, out_ready=0 -> head stays 0fff. Pop once -> out_z=0000, cond_sel=1 gives 1, cond_sel=12 gives 0, ov_count stays 1.
- Fill DEPTH=4 entries with out_ready=0 -> in_ready=0. A 5th in_valid is ignored. Drain all 4 -> FIFO order preserved, out_valid=0 after the last pop, cond_true=0.
- Continuous in_valid and out_ready for 20 cycles, data 0001..0014 -> every value appears exactly once in order; occupancy holds at 1; pointers wrap.
- clr_sticky together with a V=1 push -> sticky_v=1, ov_count=1. Drive 300 V=1 pushes with CNT_W=8 -> ov_count saturates at ff.
- With ALU_FLAG_CHECK_EN: push Z=0000 with in_zero=0 -> flag_err=1 next cycle, held until clr_sticky. Async rst_n pulse while 3 entries are queued -> out_valid=0 immediately and all outputs return to reset values.
